if_fetch_unit: RTL

//  Instruction-fetch stage of the 5-stage MIPS core. Owns the PC, issues requests to the

---
 rtl/if_fetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches over imem req/ack and
// buffers words in a 2-entry queue that feeds IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstF,
  output logic [31:0] PCF,
  output logic [31:0] PC4F,
  output logic        valid_f
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state;
  logic [31:0] npc;
  logic [1:0]  count;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];

  logic       ack, pop, flush, inflight;
  logic       busy_after, kill, push, can_issue;
  logic [1:0] cnt_pop, cnt_nxt;

  assign valid_f = count != 2'd0;
  assign InstF   = valid_f ? q_inst[0] : 32'h0;
  assign PCF     = valid_f ? q_pc[0] : 32'h0;
  assign PC4F    = valid_f ? q_pc[0] + 32'd4 : 32'h0;

  always_comb begin
    ack        = imem_req & imem_ack;
    pop        = valid_f & ~stall;
    flush      = exc | eret;
    inflight   = state != IDLE;
    busy_after = inflight & ~ack;
    // head becomes the delay slot; everything younger is discarded
    kill       = redirect & valid_f;
    push       = (state == BUSY) & ack & ~flush & ~kill;
    cnt_pop    = count - {1'b0, pop};
    cnt_nxt    = kill ? 2'd0 : cnt_pop + {1'b0, push};
    can_issue  = ~flush & ~redirect & ~busy_after &
                 (cnt_nxt != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      npc       <= RESET_PC;
      count     <= 2'd0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      q_inst[0] <= 32'h0;
      q_inst[1] <= 32'h0;
      q_pc[0]   <= 32'h0;
      q_pc[1]   <= 32'h0;
    end else begin
      count <= flush ? 2'd0 : cnt_nxt;
      if (pop) begin
        q_inst[0] <= q_inst[1];
        q_pc[0]   <= q_pc[1];
      end
      if (push) begin
        q_inst[cnt_pop[0]] <= imem_rdata;
        q_pc[cnt_pop[0]]   <= imem_addr;
      end
      if (flush) begin
        npc      <= exc ? EXC_PC : epc;
        state    <= busy_after ? DROP : IDLE;
        imem_req <= busy_after;
      end else if (redirect) begin
        npc      <= redirect_pc;
        imem_req <= busy_after;
        if (!busy_after)
          state <= IDLE;
        else if (state == BUSY && !kill)
          state <= BUSY;
        else
          state <= DROP;
      end else if (can_issue) begin
        state     <= BUSY;
        imem_req  <= 1'b1;
        imem_addr <= npc;
        npc       <= npc + 32'd4;
      end else if (!busy_after) begin
        state    <= IDLE;
        imem_req <= 1'b0;
      end
    end
  end

endmodule
